// File: rtl/mux_tree_pipe_if.sv
// Bus bundle for mux_tree_pipe: input beat, scan controls and output beat with
// valid/ready on both sides. The master drives the beat; the slave is the mux tree.
interface mux_tree_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int LEVELS = 2
);
  localparam int CHANNELS = 4 ** LEVELS;
  localparam int IW       = 2 * LEVELS;

  logic [WIDTH*CHANNELS-1:0] d;
  logic [IW-1:0]             sel;
  logic                      in_valid;
  logic                      in_ready;
  logic                      scan_en;
  logic                      scan_clr;
  logic [WIDTH-1:0]          y;
  logic [IW-1:0]             y_sel;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output d, sel, in_valid, scan_en, scan_clr, out_ready,
    input  in_ready, y, y_sel, out_valid
  );

  modport slave (
    input  d, sel, in_valid, scan_en, scan_clr, out_ready,
    output in_ready, y, y_sel, out_valid
  );
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux built from registered 4:1 levels with valid/ready flow control.
// Define MUX_TREE_PIPE_SCAN_EN to build the round-robin scan counter.
module mux_tree_pipe #(
  parameter int WIDTH  = 8,
  parameter int LEVELS = 2
) (
  input  logic             clk,
  input  logic             rst,
  mux_tree_pipe_if.slave   bus
);
  localparam int CHANNELS = 4 ** LEVELS;
  localparam int IW       = 2 * LEVELS;
  // Every stage's partial results live in one flat array, stage 0 first.
  localparam int NODES    = (CHANNELS - 1) / 3;

  function automatic int node_off(input int k);
    int off;
    off = 0;
    for (int i = 0; i < k; i++) begin
      off = off + (CHANNELS >> (2 * (i + 1)));
    end
    return off;
  endfunction

  function automatic logic [WIDTH-1:0] mux4(
    input logic [WIDTH-1:0] a0,
    input logic [WIDTH-1:0] a1,
    input logic [WIDTH-1:0] a2,
    input logic [WIDTH-1:0] a3,
    input logic [1:0]       s
  );
    logic [WIDTH-1:0] r;
    case (s)
      2'd0:    r = a0;
      2'd1:    r = a1;
      2'd2:    r = a2;
      default: r = a3;
    endcase
    return r;
  endfunction

  logic [NODES-1:0][WIDTH-1:0] node_q, node_d;
  logic [LEVELS-1:0]           vld_q, vld_d;
  logic [LEVELS-1:0][IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]               eff_idx_s;
  logic                        adv_s;

  assign adv_s         = !vld_q[LEVELS-1] || bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.y         = node_q[NODES-1];
  assign bus.y_sel     = idx_q[LEVELS-1];
  assign bus.out_valid = vld_q[LEVELS-1];

`ifdef MUX_TREE_PIPE_SCAN_EN
  logic [IW-1:0] scan_cnt_q, scan_cnt_d;

  // Effective index source.
  always_comb begin
    eff_idx_s = bus.sel;
    if (bus.scan_en) begin
      eff_idx_s = scan_cnt_q;
    end else begin
      eff_idx_s = bus.sel;
    end
  end

  // Clear wins over increment; an accepted beat still uses the pre-clear count.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    if (bus.scan_clr) begin
      scan_cnt_d = '0;
    end else if (bus.scan_en && bus.in_valid && adv_s) begin
      scan_cnt_d = scan_cnt_q + {{(IW-1){1'b0}}, 1'b1};
    end else begin
      scan_cnt_d = scan_cnt_q;
    end
  end

  // Scan counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
    end
  end
`else
  logic unused_scan_s;

  assign unused_scan_s = bus.scan_en ^ bus.scan_clr;

  // Without the counter the index always comes from sel.
  always_comb begin
    eff_idx_s = bus.sel;
  end
`endif

  // Valid and full index shift forward together on every advance.
  always_comb begin
    vld_d = vld_q;
    idx_d = idx_q;
    if (adv_s) begin
      vld_d[0] = bus.in_valid;
      idx_d[0] = eff_idx_s;
      for (int k = 1; k < LEVELS; k++) begin
        vld_d[k] = vld_q[k-1];
        idx_d[k] = idx_q[k-1];
      end
    end else begin
      vld_d = vld_q;
      idx_d = idx_q;
    end
  end

  // Stage k picks one of four predecessors using index bits [2k+1:2k].
  always_comb begin
    node_d = node_q;
    if (adv_s) begin
      for (int j = 0; j < CHANNELS / 4; j++) begin
        node_d[j] = mux4(bus.d[(4*j+0)*WIDTH +: WIDTH],
                         bus.d[(4*j+1)*WIDTH +: WIDTH],
                         bus.d[(4*j+2)*WIDTH +: WIDTH],
                         bus.d[(4*j+3)*WIDTH +: WIDTH],
                         eff_idx_s[1:0]);
      end
      for (int k = 1; k < LEVELS; k++) begin
        for (int j = 0; j < (CHANNELS >> (2 * (k + 1))); j++) begin
          node_d[node_off(k)+j] = mux4(node_q[node_off(k-1)+4*j+0],
                                       node_q[node_off(k-1)+4*j+1],
                                       node_q[node_off(k-1)+4*j+2],
                                       node_q[node_off(k-1)+4*j+3],
                                       idx_q[k-1][2*k +: 2]);
        end
      end
    end else begin
      node_d = node_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_q <= '0;
      vld_q  <= '0;
      idx_q  <= '0;
    end else begin
      node_q <= node_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
    end
  end
endmodule
